// File: rtl/instruction_refill_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_refill_unit_if
//
// Purpose:
//   Groups the two handshake buses of the instruction refill unit: the L1
//   miss/refill side and the word-granular L2/memory read port. Signal names
//   match the refill unit's external port names.
//
// Modports:
//   slave  : the refill unit. It accepts misses from L1, returns blocks to L1,
//            and issues word reads to memory.
//   master : the surroundings of the refill unit. This is the L1 miss path
//            plus the memory word port, and it is the view a testbench drives.
//
// Signals:
//   ADDRESS_TO_L2_VALID_INS  L1 -> unit   miss request valid
//   ADDRESS_TO_L2_READY_INS  unit -> L1   unit can accept a miss
//   ADDRESS_TO_L2_INS        L1 -> unit   miss word address (ADDRESS_WIDTH-2)
//   DATA_FROM_L2_VALID_INS   unit -> L1   assembled block valid
//   DATA_FROM_L2_READY_INS   L1 -> unit   L1 accepts block
//   DATA_FROM_L2_INS         unit -> L1   block, word i at [i*DW +: DW]
//   MEM_REQ_VALID            unit -> mem  word read request valid
//   MEM_REQ_READY            mem -> unit  memory accepts request
//   MEM_REQ_ADDRESS          unit -> mem  requested word address
//   MEM_RSP_VALID            mem -> unit  read data valid (no back-pressure)
//   MEM_RSP_DATA             mem -> unit  read data
//
// Handshake rule for every valid/ready pair on this interface:
//   A transfer happens on a rising edge where valid and ready are both 1.
//   The source keeps valid and payload stable until that edge. The memory
//   response has no ready and must be taken when valid.
// -----------------------------------------------------------------------------
interface instruction_refill_unit_if #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_PER_BLOCK = 16
) ();
    logic                                 ADDRESS_TO_L2_VALID_INS;
    logic                                 ADDRESS_TO_L2_READY_INS;
    logic [ADDRESS_WIDTH-3:0]             ADDRESS_TO_L2_INS;
    logic                                 DATA_FROM_L2_VALID_INS;
    logic                                 DATA_FROM_L2_READY_INS;
    logic [WORD_PER_BLOCK*DATA_WIDTH-1:0] DATA_FROM_L2_INS;
    logic                                 MEM_REQ_VALID;
    logic                                 MEM_REQ_READY;
    logic [ADDRESS_WIDTH-3:0]             MEM_REQ_ADDRESS;
    logic                                 MEM_RSP_VALID;
    logic [DATA_WIDTH-1:0]                MEM_RSP_DATA;

    modport slave (
        input  ADDRESS_TO_L2_VALID_INS,
        output ADDRESS_TO_L2_READY_INS,
        input  ADDRESS_TO_L2_INS,
        output DATA_FROM_L2_VALID_INS,
        input  DATA_FROM_L2_READY_INS,
        output DATA_FROM_L2_INS,
        output MEM_REQ_VALID,
        input  MEM_REQ_READY,
        output MEM_REQ_ADDRESS,
        input  MEM_RSP_VALID,
        input  MEM_RSP_DATA
    );

    modport master (
        output ADDRESS_TO_L2_VALID_INS,
        input  ADDRESS_TO_L2_READY_INS,
        output ADDRESS_TO_L2_INS,
        input  DATA_FROM_L2_VALID_INS,
        output DATA_FROM_L2_READY_INS,
        input  DATA_FROM_L2_INS,
        input  MEM_REQ_VALID,
        output MEM_REQ_READY,
        input  MEM_REQ_ADDRESS,
        output MEM_RSP_VALID,
        output MEM_RSP_DATA
    );
endinterface

// File: rtl/instruction_refill_unit.sv
// -----------------------------------------------------------------------------
// instruction_refill_unit
//
// Purpose:
//   This unit sits between the L1 instruction cache miss path and the L2/memory
//   word port. It accepts one miss word address at a time. It fetches the
//   WORD_PER_BLOCK words of the enclosing block, one word read at a time, and
//   assembles them into one block. It then returns the block to L1 over a
//   valid/ready handshake.
//
// Ports:
//   CLK          clock; all state changes on the rising edge
//   RSTN         synchronous active-low reset
//   bus          instruction_refill_unit_if.slave (L1 miss/refill + memory port)
//   o_dbg_state  current FSM state (IDLE=0, REQ=1, WAIT_RSP=2, DELIVER=3)
//
// Build option:
//   CRITICAL_WORD_FIRST_EN  When this macro is defined, the fetch starts at the
//                           requested word and wraps around the block. When it
//                           is undefined, the fetch always runs 0..N-1 in
//                           ascending order. The assembled block is identical
//                           in both builds; only the request order differs.
//
// The interface instance must use the same ADDRESS_WIDTH / DATA_WIDTH /
// WORD_PER_BLOCK values as this module.
// -----------------------------------------------------------------------------
module instruction_refill_unit #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_PER_BLOCK = 16
) (
    input  logic                            CLK,
    input  logic                            RSTN,
    instruction_refill_unit_if.slave        bus,
    output logic [1:0]                      o_dbg_state
);

    localparam int WA = ADDRESS_WIDTH - 2;           // word address width
    localparam int IW = $clog2(WORD_PER_BLOCK);      // word-in-block index width
    localparam int BW = WORD_PER_BLOCK * DATA_WIDTH; // block width

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    // Block-aligned part of the miss address. The index field is kept
    // separately, so the wrap of the index can never carry into the base.
    logic [WA-IW-1:0] r_base_hi;
    logic [IW-1:0]    r_idx;        // word currently being fetched
    logic [IW-1:0]    r_count;      // words already received for this miss
    logic [BW-1:0]    r_block;

    logic             w_miss_hs;    // miss accepted this cycle
    logic             w_rsp_take;   // memory word captured this cycle
    logic [IW-1:0]    w_start_idx;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start_idx = bus.ADDRESS_TO_L2_INS[IW-1:0];
`else
    assign w_start_idx = '0;
`endif

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and handshake outputs.
    // The ready and valid outputs depend only on the state. This keeps them
    // free of combinational paths from the far side of each handshake.
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state                = r_state;
        w_miss_hs                   = 1'b0;
        w_rsp_take                  = 1'b0;
        bus.ADDRESS_TO_L2_READY_INS = 1'b0;
        bus.MEM_REQ_VALID           = 1'b0;
        bus.DATA_FROM_L2_VALID_INS  = 1'b0;

        case (r_state)
            IDLE: begin
                bus.ADDRESS_TO_L2_READY_INS = 1'b1;
                if (bus.ADDRESS_TO_L2_VALID_INS) begin
                    w_miss_hs    = 1'b1;
                    w_next_state = REQ;
                end
            end

            REQ: begin
                bus.MEM_REQ_VALID = 1'b1;
                if (bus.MEM_REQ_READY) begin
                    w_next_state = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                // Responses arriving in any other state are simply never
                // looked at. That also covers stale responses after a reset.
                if (bus.MEM_RSP_VALID) begin
                    w_rsp_take = 1'b1;
                    if (r_count == IW'(WORD_PER_BLOCK - 1)) begin
                        w_next_state = DELIVER;
                    end else begin
                        w_next_state = REQ;
                    end
                end
            end

            DELIVER: begin
                bus.DATA_FROM_L2_VALID_INS = 1'b1;
                if (bus.DATA_FROM_L2_READY_INS) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: miss address latch, word index/count, block assembly
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_base_hi <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_block   <= '0;
        end else begin
            if (w_miss_hs) begin
                r_base_hi <= bus.ADDRESS_TO_L2_INS[WA-1:IW];
                r_idx     <= w_start_idx;
                r_count   <= '0;
            end
            if (w_rsp_take) begin
                r_block[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.MEM_RSP_DATA;
                r_count <= r_count + 1'b1;
                // The index width is exactly log2(WORD_PER_BLOCK), so the
                // natural overflow gives the modulo wrap.
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    // The address is formed from registers only. It therefore stays stable
    // while REQ waits for MEM_REQ_READY, and it reads 0 out of reset.
    assign bus.MEM_REQ_ADDRESS  = {r_base_hi, r_idx};
    assign bus.DATA_FROM_L2_INS = r_block;
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_instruction_refill_unit.sv
`timescale 1ns/1ps
module tb_instruction_refill_unit;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPB = 16;
  localparam int WA  = AW - 2;
  localparam int BW  = WPB * DW;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  logic [1:0] dbg_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_refill_unit_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WORD_PER_BLOCK(WPB)) bus ();

  instruction_refill_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WORD_PER_BLOCK(WPB)) dut (
    .CLK(clk),
    .RSTN(rstn),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [WA-1:0] exp_q[$];   // expected memory request addresses, in order

  task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mem_key = '0;

  function automatic logic [DW-1:0] mem_word(input logic [WA-1:0] a);
    return DW'(a) ^ mem_key;
  endfunction

  // memory model controls
  int req_num = 0;
  int stall_at = -1;
  int stall_len = 0;
  int rsp_given = 0;
  bit rand_mem = 1'b0;
  bit stray_rsp = 1'b0;

  // The model works from whole-block arithmetic. The base is the address
  // with its low 4 bits cleared. Requests visit (start+k) mod 16, and block
  // word i holds memory[base+i].
  task automatic expect_miss(input logic [WA-1:0] a, output logic [BW-1:0] blk);
    logic [WA-1:0] base;
    int start;
    base  = a & ~WA'(WPB - 1);
    start = CWF ? int'(a % WPB) : 0;
    for (int k = 0; k < WPB; k++) exp_q.push_back(base + WA'((start + k) % WPB));
    blk = '0;
    for (int i = 0; i < WPB; i++) blk[i*DW +: DW] = mem_word(base + WA'(i));
    req_num = 0;
  endtask

  // ---------------- memory responder ----------------
  // This block runs 1ns after each falling edge, so it sees the reset and
  // control flags that the main driver set on that same edge.
  initial begin : mem_model
    int rsp_cnt;
    int stall_left;
    bit holding;
    logic [WA-1:0] held_addr;
    logic [DW-1:0] rsp_word;
    rsp_cnt = 0; stall_left = 0; holding = 1'b0; held_addr = '0; rsp_word = '0;
    bus.MEM_REQ_READY = 1'b1;
    bus.MEM_RSP_VALID = 1'b0;
    bus.MEM_RSP_DATA  = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.MEM_RSP_VALID = 1'b0;
      if (stray_rsp) begin
        bus.MEM_RSP_VALID = 1'b1;
        bus.MEM_RSP_DATA  = $urandom;
      end
      if (!rstn) begin
        rsp_cnt = 0; stall_left = 0; holding = 1'b0;
        bus.MEM_REQ_READY = 1'b1;
      end else begin
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            bus.MEM_RSP_VALID = 1'b1;
            bus.MEM_RSP_DATA  = rsp_word;
            rsp_given++;
          end
        end
        if (holding) begin
          check_eq("req_hold_valid", BW'(bus.MEM_REQ_VALID), BW'(1));
          check_eq("req_hold_addr", BW'(bus.MEM_REQ_ADDRESS), BW'(held_addr));
        end
        if (bus.MEM_REQ_VALID) begin
          if (!holding) begin
            stall_left = (req_num == stall_at) ? stall_len : (rand_mem ? int'($urandom_range(0, 3)) : 0);
            held_addr  = bus.MEM_REQ_ADDRESS;
          end
          if (stall_left > 0) begin
            bus.MEM_REQ_READY = 1'b0;
            stall_left--;
            holding = 1'b1;
          end else begin
            bus.MEM_REQ_READY = 1'b1;
            holding = 1'b0;
            if (exp_q.size() == 0) check_eq("req_extra", BW'(bus.MEM_REQ_ADDRESS), '1);
            else check_eq("req_addr", BW'(bus.MEM_REQ_ADDRESS), BW'(exp_q.pop_front()));
            req_num++;
            rsp_word = mem_word(bus.MEM_REQ_ADDRESS);
            rsp_cnt  = rand_mem ? int'($urandom_range(1, 4)) : 1;
          end
        end else begin
          holding = 1'b0;
          bus.MEM_REQ_READY = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    end
  end

  // ---------------- L1 driver tasks ----------------
  // All tasks start and end on a falling edge.
  task automatic present_miss(input logic [WA-1:0] a, output logic [BW-1:0] blk, output int acc);
    int t;
    expect_miss(a, blk);
    bus.ADDRESS_TO_L2_VALID_INS = 1'b1;
    bus.ADDRESS_TO_L2_INS = a;
    t = 0;
    while (!bus.ADDRESS_TO_L2_READY_INS && t < 200) begin @(negedge clk); t++; end
    check_eq("accept_timeout", BW'(t < 200), BW'(1));
    acc = cyc + 1;
    @(negedge clk);
    bus.ADDRESS_TO_L2_VALID_INS = 1'b0;
    bus.ADDRESS_TO_L2_INS = WA'($urandom);
  endtask

  task automatic wait_block(input int acc, input int exp_lat);
    int t;
    t = 0;
    while (!bus.DATA_FROM_L2_VALID_INS && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) $display("block wait expired, dbg_state=%0d", dbg_state);
    check_eq("block_timeout", BW'(t < 3000), BW'(1));
    if (exp_lat >= 0) check_eq("latency", BW'(cyc - acc), BW'(exp_lat));
    check_eq("req_count_left", BW'(exp_q.size()), BW'(0));
  endtask

  task automatic deliver(input logic [BW-1:0] blk, input int hold, input bit nxt,
                         input logic [WA-1:0] nxt_addr, output logic [BW-1:0] nxt_blk, output int nxt_acc);
    nxt_blk = '0;
    nxt_acc = 0;
    if (nxt) begin
      expect_miss(nxt_addr, nxt_blk);
      bus.ADDRESS_TO_L2_VALID_INS = 1'b1;
      bus.ADDRESS_TO_L2_INS = nxt_addr;
    end
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", BW'(bus.DATA_FROM_L2_VALID_INS), BW'(1));
      check_eq("hold_data", bus.DATA_FROM_L2_INS, blk);
      check_eq("hold_l1_ready", BW'(bus.ADDRESS_TO_L2_READY_INS), BW'(0));
      @(negedge clk);
    end
    bus.DATA_FROM_L2_READY_INS = 1'b1;
    check_eq("blk_valid", BW'(bus.DATA_FROM_L2_VALID_INS), BW'(1));
    check_eq("blk_data", bus.DATA_FROM_L2_INS, blk);
    @(negedge clk);
    bus.DATA_FROM_L2_READY_INS = 1'b0;
    check_eq("post_valid", BW'(bus.DATA_FROM_L2_VALID_INS), BW'(0));
    check_eq("post_l1_ready", BW'(bus.ADDRESS_TO_L2_READY_INS), BW'(1));
    if (nxt) begin
      nxt_acc = cyc + 1;
      @(negedge clk);
      bus.ADDRESS_TO_L2_VALID_INS = 1'b0;
      check_eq("b2b_taken", BW'(bus.ADDRESS_TO_L2_READY_INS), BW'(0));
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_l1_ready"}, BW'(bus.ADDRESS_TO_L2_READY_INS), BW'(1));
    check_eq({tag, "_blk_valid"}, BW'(bus.DATA_FROM_L2_VALID_INS), BW'(0));
    check_eq({tag, "_req_valid"}, BW'(bus.MEM_REQ_VALID), BW'(0));
    check_eq({tag, "_req_addr"}, BW'(bus.MEM_REQ_ADDRESS), BW'(0));
    check_eq({tag, "_blk"}, bus.DATA_FROM_L2_INS, BW'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [BW-1:0] blk_a;
    logic [BW-1:0] blk_b;
    int acc_a;
    int acc_b;
    int r0;
    int t;
    rstn = 1'b0;
    bus.ADDRESS_TO_L2_VALID_INS = 1'b0;
    bus.ADDRESS_TO_L2_INS = '0;
    bus.DATA_FROM_L2_READY_INS = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Ideal memory, miss 0x43: 32-cycle latency, block word i = 0x40+i
    present_miss(WA'('h43), blk_a, acc_a);
    wait_block(acc_a, 32);
    deliver(blk_a, 0, 1'b0, '0, blk_b, acc_b);

    // Third request stalled 5 cycles: address held, 5 extra cycles
    stall_at = 2; stall_len = 5;
    present_miss(WA'('h43), blk_a, acc_a);
    wait_block(acc_a, 37);
    stall_at = -1;
    deliver(blk_a, 0, 1'b0, '0, blk_b, acc_b);

    // L1 back-pressure for 10 cycles with a second miss waiting
    present_miss(WA'('h2A7), blk_a, acc_a);
    wait_block(acc_a, 32);
    deliver(blk_a, 10, 1'b1, WA'('h100), blk_b, acc_b);
    wait_block(acc_b, 32);
    deliver(blk_b, 0, 1'b0, '0, blk_a, acc_a);

    // Reset right after the 7th response, then a stray response
    mem_key = 32'h5A5A_0000;
    present_miss(WA'('h43), blk_a, acc_a);
    r0 = rsp_given;
    t = 0;
    while (rsp_given < r0 + 7 && t < 500) begin @(negedge clk); t++; end
    check_eq("seventh_rsp_timeout", BW'(t < 500), BW'(1));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    stray_rsp = 1'b1;
    check_idle("midreset");
    @(negedge clk);
    stray_rsp = 1'b0;
    check_eq("stray_l1_ready", BW'(bus.ADDRESS_TO_L2_READY_INS), BW'(1));
    check_eq("stray_req_valid", BW'(bus.MEM_REQ_VALID), BW'(0));
    check_eq("stray_blk", bus.DATA_FROM_L2_INS, BW'(0));
    mem_key = 32'h0;
    present_miss(WA'('h100), blk_a, acc_a);
    wait_block(acc_a, 32);
    deliver(blk_a, 0, 1'b0, '0, blk_b, acc_b);

    // Back-to-back misses 0x10 then 0xFF0, second held valid
    present_miss(WA'('h10), blk_a, acc_a);
    wait_block(acc_a, 32);
    deliver(blk_a, 0, 1'b1, WA'('hFF0), blk_b, acc_b);
    wait_block(acc_b, 32);
    deliver(blk_b, 0, 1'b0, '0, blk_a, acc_a);

    // Randomized traffic: random addresses, stalls, response delays, L1 holds
    rand_mem = 1'b1;
    mem_key = $urandom;
    for (int n = 0; n < 24; n++) begin
      present_miss(WA'($urandom), blk_a, acc_a);
      wait_block(acc_a, -1);
      deliver(blk_a, int'($urandom_range(0, 3)), 1'b0, '0, blk_b, acc_b);
    end
    rand_mem = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got total=%0d expected completion", total);
    $fatal(1, "watchdog");
  end
endmodule
